ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clock-low hold before request-to-send (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, maximum iCLK cycles allowed between device clock falling edges (20 ms).
REQ-003 SHALL have port iCLK, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port iRST_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port iData, input, 8, command byte to send.
REQ-006 SHALL have port iSend, input, 1, start strobe, sampled only in IDLE.
REQ-007 SHALL have port iPS2_clk, input, 1, PS/2 clock line as seen on the pin.
REQ-008 SHALL have port iPS2_data, input, 1, PS/2 data line as seen on the pin.
REQ-009 SHALL have port oPS2_clk_oe, output, 1, 1 = pull clock line low, 0 = release.
REQ-010 SHALL have port oPS2_data_oe, output, 1, 1 = pull data line low, 0 = release.
REQ-011 SHALL have port oBusy, output, 1, high from the cycle after an accepted iSend until the frame ends.
REQ-012 SHALL have port oDone, output, 1, one-cycle pulse on an acknowledged frame.
REQ-013 SHALL have port oErr, output, 1, one-cycle pulse on a missing acknowledge or a timeout.

Function
REQ-014 SHALL pass iPS2_clk and iPS2_data through 2-FF synchronizers; a device clock falling edge is synchronized clock previous=1, current=0.
REQ-015 SHALL implement the states IDLE, INHIBIT, RTS, SHIFT, ACK and WAIT_IDLE.
REQ-016 In IDLE, iSend=1 SHALL latch iData and compute the odd parity bit P = ~^iData, then enter INHIBIT on the next cycle; oBusy rises on that same cycle.
REQ-017 INHIBIT SHALL hold oPS2_clk_oe=1 for exactly INHIBIT_CYCLES cycles, assert oPS2_data_oe=1 on the last cycle, then enter RTS.
REQ-018 RTS SHALL hold oPS2_clk_oe=0 and oPS2_data_oe=1 (start bit 0), and SHALL enter SHIFT on the first falling edge.
REQ-019 SHIFT SHALL use a 4-bit counter. On the first falling edge it drives D0; on the following falling edges it drives D1..D7, then P, then the stop bit (data released). In every case oPS2_data_oe = ~bit.
REQ-020 The falling edge after the stop bit SHALL move the block to ACK. Bit order is LSB-first.
REQ-021 In ACK, synchronized data=0 at the next falling edge SHALL mean acknowledged and move to WAIT_IDLE. Data=1 SHALL pulse oErr and return to IDLE.
REQ-022 WAIT_IDLE SHALL wait until both synchronized lines are high, then pulse oDone and return to IDLE.
REQ-023 The timeout counter SHALL clear on every falling edge and on entry to RTS.
REQ-024 In RTS, SHIFT, ACK or WAIT_IDLE, reaching TIMEOUT_CYCLES SHALL release both lines, pulse oErr and return to IDLE.
REQ-025 iSend outside IDLE SHALL be ignored; the latched byte is unchanged.
REQ-026 oDone and oErr SHALL never be asserted in the same cycle.
REQ-027 oBusy SHALL be low in the cycle that oDone or oErr pulses.
REQ-028 Both oe outputs SHALL be 0 in IDLE.

Reset
REQ-029 iRST_n=0 SHALL immediately force state IDLE, with oPS2_clk_oe, oPS2_data_oe, oBusy, oDone and oErr all 0.
REQ-030 iRST_n=0 SHALL also clear all counters and synchronizers (synchronizers to 1), including when asserted mid-frame.
REQ-031 After reset release, the first frame SHALL require a new iSend.

Structure
REQ-032 Shared package ps2_pkg SHALL hold the state enum and the command constants: 8'hFF reset, 8'hED set-LEDs, 8'hF4 enable, 8'hFE resend.
REQ-033 ps2_pkg SHALL also hold the existing scan-code constants (8'hF0, 8'hE0, 8'h74, 8'h6B).
REQ-034 Sub-module ps2_sync_edge SHALL hold the 2-FF synchronizer and the falling-edge detector, reusable by the receive side.

Verification
REQ-035 Send 8'hED with a device model clocking at 12 kHz. Required: oPS2_clk_oe high for exactly 5000 cycles; data bits 1,0,1,1,0,1,1,1; parity 1; stop released; ack 0; one oDone pulse; oErr never set.
REQ-036 Send 8'h01, then 8'hFF. Required: parity bits 0 and 1 respectively.
REQ-037 Device releases data in the ack slot. Required: oErr pulses once, oDone stays 0, both oe outputs are 0 in the next cycle.
REQ-038 Device never clocks after RTS. Required: oErr exactly TIMEOUT_CYCLES cycles after RTS entry, both lines released, state IDLE.
REQ-039 Pulse iSend with 8'hAA during an 8'hF4 frame. Required: the frame carries 8'hF4 only, and only one oDone pulse occurs.
REQ-040 Drop iRST_n after the 4th data bit. Required: all outputs 0 immediately; a following iSend of 8'hFF completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, host command bytes,
// keyboard scan-code constants and the frame parity helper.
package ps2_pkg;

    // Host transmit state machine
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    // Host-to-device command bytes
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESEND   = 8'hFE;

    // Scan codes shared with the receive side
    localparam logic [7:0] SC_BREAK     = 8'hF0;
    localparam logic [7:0] SC_EXTENDED  = 8'hE0;
    localparam logic [7:0] SC_RIGHT     = 8'h74;
    localparam logic [7:0] SC_LEFT      = 8'h6B;

    // Bit slot index of the stop bit within the shifted part of the frame
    // (0..7 data, 8 parity, 9 stop)
    localparam logic [3:0] STOP_SLOT    = 4'd9;

    // Odd parity: the parity bit makes the total count of ones odd
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a falling-edge
// detector on the synchronized clock. Shared by the transmit and receive paths.
// Both lines idle high, so every flop resets to 1 and no edge is seen on reset
// release.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic clk_meta;
    logic data_meta;
    logic clk_prev;

    // Resynchronize both pins and keep the previous synchronized clock value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
            clk_prev  <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
            clk_prev  <= clk_sync;
        end
    end

    assign clk_fall = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues a request-to-send,
// shifts the command byte LSB-first with odd parity on device clock falling
// edges, checks the device acknowledge and waits for the bus to go idle.
// Open-collector style outputs: an *_oe of 1 pulls the line low.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       iCLK,
    input  logic       iRST_n,
    input  logic [7:0] iData,
    input  logic       iSend,
    input  logic       iPS2_clk,
    input  logic       iPS2_data,
    output logic       oPS2_clk_oe,
    output logic       oPS2_data_oe,
    output logic       oBusy,
    output logic       oDone,
    output logic       oErr
);

    localparam int               INH_W    = $clog2(INHIBIT_CYCLES + 1);
    localparam int               TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [7:0]       tx_byte;
    logic             parity;
    logic [3:0]       bit_cnt;
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             drive_low;
    logic             done;
    logic             err;

    logic             clk_sync;
    logic             data_sync;
    logic             clk_fall;
    logic             bus_active;
    logic             timeout_hit;

    // Value carried in a given shifted slot: data LSB-first, parity, stop
    function automatic logic frame_bit(input logic [7:0] b, input logic p,
                                       input logic [3:0] slot);
        if (slot < 4'd8)
            return b[slot[2:0]];
        else if (slot == 4'd8)
            return p;
        else
            return 1'b1;
    endfunction

    ps2_sync_edge u_sync (
        .clk       (iCLK),
        .rst_n     (iRST_n),
        .ps2_clk   (iPS2_clk),
        .ps2_data  (iPS2_data),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .clk_fall  (clk_fall)
    );

    // States in which the device owns the clock and the timeout applies
    assign bus_active  = (state == ST_RTS) || (state == ST_SHIFT) ||
                         (state == ST_ACK) || (state == ST_WAIT_IDLE);
    assign timeout_hit = bus_active && (to_cnt == TO_LAST);

    // Device-clock watchdog: restarts on every falling edge, held at zero
    // until request-to-send begins
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n)
            to_cnt <= '0;
        else if (!bus_active || clk_fall || timeout_hit)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end

    // Frame sequencing, bit shifting and completion pulses
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state     <= ST_IDLE;
            tx_byte   <= '0;
            parity    <= 1'b0;
            bit_cnt   <= '0;
            inh_cnt   <= '0;
            drive_low <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (timeout_hit) begin
                state     <= ST_IDLE;
                drive_low <= 1'b0;
                err       <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        drive_low <= 1'b0;
                        if (iSend) begin
                            tx_byte <= iData;
                            parity  <= odd_parity(iData);
                            inh_cnt <= '0;
                            state   <= ST_INHIBIT;
                        end
                    end
                    ST_INHIBIT: begin
                        if (inh_cnt == INH_LAST) begin
                            drive_low <= 1'b1;          // start bit
                            state     <= ST_RTS;
                        end else begin
                            inh_cnt <= inh_cnt + 1'b1;
                        end
                    end
                    ST_RTS: begin
                        if (clk_fall) begin
                            bit_cnt   <= '0;
                            drive_low <= ~tx_byte[0];
                            state     <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (clk_fall) begin
                            if (bit_cnt == STOP_SLOT) begin
                                drive_low <= 1'b0;
                                state     <= ST_ACK;
                            end else begin
                                bit_cnt   <= bit_cnt + 4'd1;
                                drive_low <= ~frame_bit(tx_byte, parity, bit_cnt + 4'd1);
                            end
                        end
                    end
                    ST_ACK: begin
                        if (clk_fall) begin
                            if (!data_sync) begin
                                state <= ST_WAIT_IDLE;
                            end else begin
                                err   <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (clk_sync && data_sync) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        drive_low <= 1'b0;
                        state     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign oPS2_clk_oe  = (state == ST_INHIBIT);
    assign oPS2_data_oe = (state == ST_INHIBIT) ? (inh_cnt == INH_LAST)
                                                : (drive_low && ((state == ST_RTS) || (state == ST_SHIFT)));
    assign oBusy        = (state != ST_IDLE);
    assign oDone        = done;
    assign oErr         = err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// a scoreboard queue holds the expected outcome and frame bits of every send,
// and a monitor pops and compares each time the DUT pulses oDone or oErr.
// iCLK stands for a 5 MHz clock here, so 500 inhibit cycles are 100 us and a
// 12 kHz device clock has a period of about 416 cycles.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH       = 500;
    localparam int TO        = 2500;
    localparam int HALF_12K  = 208;
    localparam int HALF_FAST = 20;

    typedef struct {
        bit          is_err;
        bit          chk_bits;
        logic [10:0] bits;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       send = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clk_oe, data_oe, busy, done, err;
    logic       ps2_clk_line, ps2_data_line;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          exp_done = 0;
    int          run = 0;
    int          last_run = 0;
    int          both_cnt = 0;
    bit          chk_release = 0;
    logic [10:0] cap = '0;

    logic [7:0] b;
    bit         ack;
    int         d0, e0, t, t0, t1, bsum;

    // Wired-AND bus with pull-ups
    assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
    assign ps2_data_line = ~(data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .iCLK         (clk),
        .iRST_n       (rst_n),
        .iData        (data),
        .iSend        (send),
        .iPS2_clk     (ps2_clk_line),
        .iPS2_data    (ps2_data_line),
        .oPS2_clk_oe  (clk_oe),
        .oPS2_data_oe (data_oe),
        .oBusy        (busy),
        .oDone        (done),
        .oErr         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference frame as the device sees it: start 0, data LSB-first,
    // parity making the count of ones odd, stop 1
    function automatic logic [10:0] frame_of(input logic [7:0] v);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[1 + i] = v[i];
            if (v[i]) ones++;
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    function automatic exp_t mk_exp(input bit is_err, input bit chk, input logic [10:0] bits);
        exp_t e;
        e.is_err   = is_err;
        e.chk_bits = chk;
        e.bits     = bits;
        return e;
    endfunction

    // Monitor: pops the scoreboard on every completion pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (clk_oe) run++;
            else if (run != 0) begin
                last_run = run;
                run = 0;
            end
            if (clk_oe && data_oe) both_cnt++;
            if (rst_n) begin
                if (chk_release) begin
                    check("release_after_err", 32'({clk_oe, data_oe}), 32'd0);
                    chk_release = 0;
                end
                if (done || err) begin
                    check("done_err_exclusive", 32'(done & err), 32'd0);
                    check("busy_low_at_pulse", 32'(busy), 32'd0);
                    if (done) done_cnt++;
                    if (err) begin
                        err_cnt++;
                        chk_release = 1;
                    end
                    if (sb.size() == 0) begin
                        check("unexpected_pulse", 32'({done, err}), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("outcome_err", 32'(err), 32'(e.is_err));
                        if (e.chk_bits) check("frame_bits", 32'(cap), 32'(e.bits));
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] v);
        @(negedge clk);
        data = v;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        data = 8'($urandom);
        check("busy_rise", 32'(busy), 32'd1);
    endtask

    // Device model: waits for request-to-send, then generates falling edges,
    // sampling the data line at the end of each low phase; optionally
    // acknowledges, and stops early (clock held low) after max_edges edges.
    task automatic dev_frame(input int half, input bit ack_ok, input int max_edges);
        int w;
        w = 0;
        while (!(busy && !clk_oe && data_oe) && w < 20000) begin
            @(negedge clk);
            w++;
        end
        check("rts_seen", 32'(w < 20000), 32'd1);
        repeat (half) @(negedge clk);
        cap[0] = ps2_data_line;
        for (int k = 1; k <= 12; k++) begin
            dev_clk_low = 1'b1;
            repeat (half) @(negedge clk);
            if (k <= 10) cap[k] = ps2_data_line;
            if (k == 11 && ack_ok) dev_data_low = 1'b1;
            if (k == max_edges && max_edges < 12) return;
            dev_clk_low = 1'b0;
            if (k == 12) dev_data_low = 1'b0;
            repeat (half) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy && w < 8000) begin
            @(negedge clk);
            w++;
        end
        check("frame_end", 32'(w < 8000), 32'd1);
        repeat (5) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] v, input int half, input bit ack_ok);
        sb.push_back(mk_exp(!ack_ok, 1'b1, frame_of(v)));
        if (ack_ok) exp_done++;
        send_byte(v);
        dev_frame(half, ack_ok, 12);
        wait_idle();
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("reset_outputs", 32'({clk_oe, data_oe, busy, done, err}), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Set-LEDs command with a 12 kHz device
        both_cnt = 0;
        frame(CMD_SET_LEDS, HALF_12K, 1'b1);
        check("inhibit_len", 32'(last_run), 32'(INH));
        check("inhibit_data_last_only", 32'(both_cnt), 32'd1);
        check("ed_parity", 32'(cap[9]), 32'd1);
        check("ed_done_count", 32'(done_cnt), 32'd1);
        check("ed_err_count", 32'(err_cnt), 32'd0);

        // Parity corner bytes
        frame(8'h01, HALF_FAST, 1'b1);
        check("parity_01", 32'(cap[9]), 32'd0);
        frame(CMD_RESET, HALF_FAST, 1'b1);
        check("parity_ff", 32'(cap[9]), 32'd1);

        // Random bytes with random acknowledge
        for (int i = 0; i < 5; i++) begin
            b   = 8'($urandom);
            ack = 1'($urandom_range(0, 1));
            frame(b, HALF_FAST, ack);
        end

        // Device leaves data released in the ack slot
        d0 = done_cnt;
        e0 = err_cnt;
        frame(8'h5A, HALF_FAST, 1'b0);
        check("nack_err_once", 32'(err_cnt - e0), 32'd1);
        check("nack_no_done", 32'(done_cnt - d0), 32'd0);

        // Device never clocks after request-to-send
        sb.push_back(mk_exp(1'b1, 1'b0, '0));
        send_byte(8'h3C);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(busy && !clk_oe && data_oe) && t < 2000);
        t0 = cyc;
        t = 0;
        while (!err && t < TO + 200) begin
            @(negedge clk);
            t++;
        end
        t1 = cyc;
        check("timeout_seen", 32'(t < TO + 200), 32'd1);
        check("timeout_latency", 32'(t1 - t0), 32'(TO));
        check("timeout_release", 32'({clk_oe, data_oe, busy}), 32'd0);
        repeat (5) @(negedge clk);

        // Second send request during an enable frame is ignored
        d0 = done_cnt;
        sb.push_back(mk_exp(1'b0, 1'b1, frame_of(CMD_ENABLE)));
        exp_done++;
        send_byte(CMD_ENABLE);
        fork
            dev_frame(HALF_FAST, 1'b1, 12);
            begin
                repeat (INH + 100) @(negedge clk);
                data = 8'hAA;
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
            end
        join
        wait_idle();
        repeat (50) @(negedge clk);
        check("f4_single_done", 32'(done_cnt - d0), 32'd1);

        // Reset after the 4th data bit
        send_byte(8'h96);
        dev_frame(HALF_FAST, 1'b1, 4);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_mid_frame", 32'({clk_oe, data_oe, busy, done, err}), 32'd0);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bsum = 0;
        repeat (20) begin
            @(negedge clk);
            bsum += 32'(busy);
        end
        check("no_restart_after_reset", 32'(bsum), 32'd0);
        frame(CMD_RESET, HALF_FAST, 1'b1);
        check("ff_after_reset_parity", 32'(cap[9]), 32'd1);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("total_done", 32'(done_cnt), 32'(exp_done));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global bound on run time
    initial begin
        #3000000;
        $display("FAIL watchdog cycles=%0d required=finish", cyc);
        $fatal(1);
    end

endmodule
